// File: rtl/prog_loader.sv
// Serial program loader: parses a count/words/checksum byte frame, writes 16-bit words
// into instruction memory and holds the cpu in reset until the image checks out.
module prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 100000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int                GAP_W     = $clog2(TIMEOUT + 1);
    localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, RUN, ERROR} state_t;

    state_t            state, state_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic [7:0]        hi, hi_nxt;
    logic [16:0]       idx, idx_nxt;
    logic [7:0]        sum, sum_nxt;
    logic [GAP_W-1:0]  gap, gap_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [15:0]       mem_wdata_nxt;
    logic [1:0]        err_code_nxt;
    logic [16:0]       words, idx_inc;
    logic              timed;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= CNT_HI;
            cnt       <= '0;
            hi        <= '0;
            idx       <= '0;
            sum       <= '0;
            gap       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_code  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hi        <= hi_nxt;
            idx       <= idx_nxt;
            sum       <= sum_nxt;
            gap       <= gap_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            err_code  <= err_code_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hi_nxt        = hi;
        idx_nxt       = idx;
        sum_nxt       = sum;
        gap_nxt       = gap;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        err_code_nxt  = err_code;
        words         = {1'b0, cnt[15:8], rx_data};
        idx_inc       = idx + 17'd1;
        timed         = (state == CNT_LO) || (state == DATA_HI) ||
                        (state == DATA_LO) || (state == CHECK);

        // load_req outranks everything, including a byte arriving the same cycle
        if (load_req) begin
            state_nxt    = CNT_HI;
            sum_nxt      = '0;
            idx_nxt      = '0;
            gap_nxt      = '0;
            err_code_nxt = '0;
        end else begin
            if (rx_valid) begin
                gap_nxt = '0;
            end else if (timed) begin
                gap_nxt = gap + GAP_W'(1);
                if (gap == GAP_LAST) begin
                    state_nxt    = ERROR;
                    err_code_nxt = 2'd2;
                end
            end

            if (rx_valid) begin
                case (state)
                    CNT_HI: begin
                        cnt_nxt[15:8] = rx_data;
                        sum_nxt       = sum + rx_data;
                        state_nxt     = CNT_LO;
                    end
                    CNT_LO: begin
                        cnt_nxt = words[15:0];
                        sum_nxt = sum + rx_data;
                        idx_nxt = '0;
                        if (words > MAX_WORDS) begin
                            state_nxt    = ERROR;
                            err_code_nxt = 2'd3;
                        end else if (words == 17'd0) begin
                            state_nxt = CHECK;
                        end else begin
                            state_nxt = DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        hi_nxt    = rx_data;
                        sum_nxt   = sum + rx_data;
                        state_nxt = DATA_LO;
                    end
                    DATA_LO: begin
                        sum_nxt       = sum + rx_data;
                        mem_we_nxt    = 1'b1;
                        mem_addr_nxt  = idx[ADDR_W-1:0];
                        mem_wdata_nxt = {hi, rx_data};
                        idx_nxt       = idx_inc;
                        state_nxt     = (idx_inc == {1'b0, cnt}) ? CHECK : DATA_HI;
                    end
                    CHECK: begin
                        if (rx_data == sum) begin
                            state_nxt = RUN;
                        end else begin
                            state_nxt    = ERROR;
                            err_code_nxt = 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cpu_rst_n = (state == RUN);
    assign done      = (state == RUN);
    assign err       = (state == ERROR);
endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame bench for prog_loader; a frame-level reference model predicts
// the write list and final status for each frame.
module tb_prog_loader;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              load_req = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_rst_n, done, err;
    logic [1:0]        err_code;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  fr[$];
    logic [31:0] wlog[$];
    logic [31:0] exp_w[$];
    logic        exp_done;
    logic [1:0]  exp_code;

    prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data),
        .load_req(load_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .done(done),
        .err(err), .err_code(err_code)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (mem_we) wlog.push_back({16'(mem_addr), mem_wdata});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge CLK);
        if (gap > 0) #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge CLK); #1;
        load_req = 1'b0;
    endtask

    // Frame-level reference: decode count, list writes, verify checksum.
    task automatic model_frame();
        int n, s;
        exp_w.delete();
        n = (int'(fr[0]) << 8) | int'(fr[1]);
        if (n > (1 << ADDR_W)) begin
            exp_done = 1'b0;
            exp_code = 2'd3;
            return;
        end
        s = int'(fr[0]) + int'(fr[1]);
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({16'(i), fr[2 + 2*i], fr[3 + 2*i]});
            s += int'(fr[2 + 2*i]) + int'(fr[3 + 2*i]);
        end
        if (int'(fr[2 + 2*n]) == (s & 255)) begin
            exp_done = 1'b1;
            exp_code = 2'd0;
        end else begin
            exp_done = 1'b0;
            exp_code = 2'd1;
        end
    endtask

    task automatic run_frame(input string tag, input bit do_load, input int maxgap);
        int bad;
        if (do_load) pulse_load();
        wlog.delete();
        model_frame();
        foreach (fr[i]) send(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        repeat (2) @(posedge CLK); #1;
        chk({tag, ":done"}, done, exp_done);
        chk({tag, ":cpu_rst_n"}, cpu_rst_n, exp_done);
        chk({tag, ":err"}, err, exp_code != 2'd0);
        chk({tag, ":err_code"}, err_code, exp_code);
        chk({tag, ":nwr"}, wlog.size(), exp_w.size());
        bad = 0;
        foreach (exp_w[i]) if (i >= wlog.size() || wlog[i] !== exp_w[i]) bad++;
        chk({tag, ":wr_mismatches"}, bad, 0);
    endtask

    task automatic build_random();
        int n, s, cs;
        fr.delete();
        n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1025, 65535)) : int'($urandom_range(0, 6));
        fr.push_back(n[15:8]);
        fr.push_back(n[7:0]);
        if (n <= 1024) begin
            for (int i = 0; i < 2*n; i++) fr.push_back(8'($urandom));
            s = 0;
            foreach (fr[i]) s += int'(fr[i]);
            cs = s & 255;
            if ($urandom_range(0, 3) == 0) cs = (cs + int'($urandom_range(1, 255))) & 255;
            fr.push_back(cs[7:0]);
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK); #1;
        chk("rst:cpu_rst_n", cpu_rst_n, 0);
        chk("rst:done", done, 0);
        chk("rst:err", err, 0);
        chk("rst:err_code", err_code, 0);
        chk("rst:mem_we", mem_we, 0);
        chk("rst:mem_addr", mem_addr, 0);
        chk("rst:mem_wdata", mem_wdata, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // first frame byte by byte to pin write and RUN latency
        wlog.delete();
        send(8'h00, 0); send(8'h02, 0); send(8'h60, 0); send(8'h01, 0);
        chk("f1:we0", mem_we, 1);
        chk("f1:addr0", mem_addr, 0);
        chk("f1:data0", mem_wdata, 16'h6001);
        send(8'hF0, 0); send(8'h00, 0);
        chk("f1:we1", mem_we, 1);
        chk("f1:addr1", mem_addr, 1);
        chk("f1:data1", mem_wdata, 16'hF000);
        send(8'h53, 0);
        chk("f1:done", done, 1);
        chk("f1:cpu_rst_n", cpu_rst_n, 1);
        send(8'h11, 0); send(8'h22, 2);
        chk("f1:nwr", wlog.size(), 2);
        chk("f1:hold_addr", mem_addr, 1);
        chk("f1:still_done", done, 1);

        fr = '{8'h00, 8'h02, 8'h60, 8'h01, 8'hF0, 8'h00, 8'h54};
        run_frame("badsum", 1, 0);
        fr = '{8'h00, 8'h02, 8'h60, 8'h01, 8'hF0, 8'h00, 8'h53};
        run_frame("reload", 1, 0);

        // inter-byte timeout
        pulse_load();
        wlog.delete();
        send(8'h00, 0); send(8'h01, 0); send(8'h12, 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge CLK); #1;
            if (k == TIMEOUT - 1) chk("to:err_early", err, 0);
        end
        chk("to:err", err, 1);
        chk("to:err_code", err_code, 2);
        chk("to:cpu_rst_n", cpu_rst_n, 0);
        chk("to:nwr", wlog.size(), 0);

        // count overflow seen the cycle after the low count byte
        pulse_load();
        wlog.delete();
        send(8'h04, 0); send(8'h01, 0);
        chk("ovf:err", err, 1);
        chk("ovf:err_code", err_code, 3);
        repeat (2) @(posedge CLK); #1;
        chk("ovf:nwr", wlog.size(), 0);

        // full-depth image
        fr.delete();
        fr.push_back(8'h04); fr.push_back(8'h00);
        for (int i = 0; i < 2048; i++) fr.push_back(8'h00);
        fr.push_back(8'h04);
        run_frame("full", 1, 0);
        chk("full:last_addr", wlog.size() > 0 ? wlog[wlog.size()-1][31:16] : 32'hFFFF, 1023);

        fr = '{8'h00, 8'h00, 8'h00};
        run_frame("empty", 1, 0);

        // async reset mid-frame, with a write pulse in flight
        pulse_load();
        send(8'h00, 0); send(8'h03, 0); send(8'hAA, 0); send(8'hBB, 0);
        #2 RST = 1'b0;
        #1;
        chk("arst:mem_we", mem_we, 0);
        chk("arst:mem_addr", mem_addr, 0);
        chk("arst:mem_wdata", mem_wdata, 0);
        chk("arst:done", done, 0);
        chk("arst:err", err, 0);
        chk("arst:cpu_rst_n", cpu_rst_n, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        fr = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h79};
        run_frame("post_rst", 0, 0);

        // load_req with a coincident byte: byte must be dropped
        rx_valid = 1'b1; rx_data = 8'hFF; load_req = 1'b1;
        @(posedge CLK); #1;
        rx_valid = 1'b0; load_req = 1'b0;
        fr = '{8'h00, 8'h00, 8'h00};
        run_frame("lr_drop", 0, 0);

        for (int t = 0; t < 30; t++) begin
            build_random();
            run_frame($sformatf("rnd%0d", t), 1, 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
